// File: rtl/riscv_pipe_pkg.sv
// Shared types and defaults for the pipeline's unified memory arbiter.
package riscv_pipe_pkg;

  // Arbiter transaction state: which owner (if any) has a response pending.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    BUSY_X = 2'd3
  } arb_state_t;

  // Requester identity used when describing a winner or an owner.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  // Default bound on consecutive data grants while a fetch waits.
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational winner select: data first while under the starvation
// bound, then fetch, then data again. A fetch that is being killed in
// the same cycle is not eligible.
module arb_prio_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic i_kill,
  input  logic i_starve_ok,
  output logic o_pick_i,
  output logic o_pick_d
);

  logic w_fetch_ok;

  assign w_fetch_ok = i_req & ~i_kill;

  // Priority chain; at most one pick is ever high.
  always_comb begin
    o_pick_i = 1'b0;
    o_pick_d = 1'b0;
    if (d_req && i_starve_ok) begin
      o_pick_d = 1'b1;
    end else if (w_fetch_ok) begin
      o_pick_i = 1'b1;
    end else if (d_req) begin
      o_pick_d = 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store
// port. One transaction outstanding at most; responses are steered back to
// their owner, and a killed fetch has its response swallowed.
module unified_mem_arbiter
  import riscv_pipe_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_kill,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  // memory port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_next;
  logic       r_store;

  logic w_slot;
  logic w_starve_ok;
  logic w_pick_i;
  logic w_pick_d;
  logic w_issue_i;
  logic w_issue_d;

  // IDLE is always an issue slot; a busy state frees up in its response cycle.
  assign w_slot      = (r_state == IDLE) | mem_rvalid;
  assign w_starve_ok = (r_starve_cnt < LP_STARVE_MAX);

  arb_prio_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .i_kill      (i_kill),
    .i_starve_ok (w_starve_ok),
    .o_pick_i    (w_pick_i),
    .o_pick_d    (w_pick_d)
  );

  assign w_issue_i = w_slot & w_pick_i;
  assign w_issue_d = w_slot & w_pick_d;

  assign mem_req = w_issue_i | w_issue_d;
  assign i_gnt   = w_issue_i & mem_ready;
  assign d_gnt   = w_issue_d & mem_ready;

  // Memory request fields follow the winner; fetch never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_issue_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (w_issue_i) begin
      mem_addr  = i_addr;
    end
  end

  // Response steering; a same-cycle kill suppresses the fetch response,
  // and a store acknowledge carries no data.
  always_comb begin
    i_rvalid = (r_state == BUSY_I) & mem_rvalid & ~i_kill;
    d_rvalid = (r_state == BUSY_D) & mem_rvalid;
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = (d_rvalid & ~r_store) ? mem_rdata : '0;
  end

  // Next-state: a slot reissues or drops to IDLE; otherwise hold, except
  // that killing an outstanding fetch marks its response for discard.
  always_comb begin
    w_state_next = r_state;
    if (w_slot) begin
      if (i_gnt) begin
        w_state_next = BUSY_I;
      end else if (d_gnt) begin
        w_state_next = BUSY_D;
      end else begin
        w_state_next = IDLE;
      end
    end else if ((r_state == BUSY_I) && i_kill) begin
      w_state_next = BUSY_X;
    end
  end

  // Starvation counter: counts data grants taken while fetch is waiting.
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (!i_req || i_gnt) begin
      w_starve_next = 4'd0;
    end else if (d_gnt && (r_starve_cnt < LP_STARVE_MAX)) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
  end

  // State, counter and the store flag of the outstanding data access.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      r_store      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      if (d_gnt) begin
        r_store <= d_we;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cycle vectors, a starvation
// sequence, then randomized traffic against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_kill, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs of one cycle.
  logic        e_ig, e_dg, e_irv, e_drv, e_mreq, e_mwe;
  logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
  logic [3:0]  e_mbe;

  task automatic check_all(input string tag);
    chk({tag, ".i_gnt"},     32'(i_gnt),     32'(e_ig));
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'(e_dg));
    chk({tag, ".i_rvalid"},  32'(i_rvalid),  32'(e_irv));
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'(e_drv));
    chk({tag, ".i_rdata"},   i_rdata,        e_irdata);
    chk({tag, ".d_rdata"},   d_rdata,        e_drdata);
    chk({tag, ".mem_req"},   32'(mem_req),   32'(e_mreq));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(e_mwe));
    chk({tag, ".mem_addr"},  mem_addr,       e_maddr);
    chk({tag, ".mem_wdata"}, mem_wdata,      e_mwdata);
    chk({tag, ".mem_be"},    32'(mem_be),    32'(e_mbe));
  endtask

  typedef struct {
    logic        rn, ireq;
    logic [31:0] iaddr;
    logic        ikill, dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        mrdy, mrv;
    logic [31:0] mrdata;
    logic        x_ig, x_dg, x_irv, x_drv, x_mreq, x_mwe;
    logic [31:0] x_maddr, x_mwdata;
    logic [3:0]  x_mbe;
    logic [31:0] x_irdata, x_drdata;
  } vec_t;

  vec_t tv [23];

  // Transaction-level reference: the one outstanding access, if any.
  int   q_own;      // 0 none, 1 fetch, 2 data
  bit   q_killed, q_store;
  int   q_run;      // data grants taken while fetch waited
  int   n_own, n_run;
  bit   n_killed, n_store;

  task automatic model_eval();
    bit have, resp, slot;
    int win;
    have = (q_own != 0);
    resp = have && mem_rvalid;
    slot = !have || resp;
    e_irv = resp && q_own == 1 && !q_killed && !i_kill;
    e_drv = resp && q_own == 2;
    e_irdata = e_irv ? mem_rdata : 32'h0;
    e_drdata = (e_drv && !q_store) ? mem_rdata : 32'h0;
    win = 0;
    if (slot) begin
      if (d_req && q_run < SM) win = 2;
      else if (i_req && !i_kill) win = 1;
      else if (d_req) win = 2;
    end
    e_mreq   = (win != 0);
    e_ig     = (win == 1) && mem_ready;
    e_dg     = (win == 2) && mem_ready;
    e_mwe    = (win == 2) ? d_we : 1'b0;
    e_maddr  = (win == 2) ? d_addr : (win == 1) ? i_addr : 32'h0;
    e_mwdata = (win == 2) ? d_wdata : 32'h0;
    e_mbe    = (win == 2) ? d_be : 4'h0;
    if (slot) begin
      n_own = e_ig ? 1 : (e_dg ? 2 : 0);
      n_killed = 1'b0;
      n_store = e_dg ? d_we : 1'b0;
    end else begin
      n_own = q_own;
      n_killed = q_killed || (q_own == 1 && i_kill);
      n_store = q_store;
    end
    if (!i_req || e_ig) n_run = 0;
    else if (e_dg) n_run = (q_run + 1 > SM) ? SM : q_run + 1;
    else n_run = q_run;
  endtask

  initial begin
    bit p_i, p_d;
    logic [31:0] pi_addr;
    bool_dummy: begin end
    resetn = 1'b0; i_req = 0; i_addr = 0; i_kill = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

    //            rn ir iaddr  ik dr dw daddr   dwdata    be  rdy rv rdata          ig dg irv drv mrq mwe maddr  mwdata   mbe irdata        drdata
    tv[0]  = '{1,0,0,      0,0,0,0,      0,        0,  0,0,0,              0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[1]  = '{1,0,0,      0,1,0,'h100,  0,        'hF,1,0,0,              0,1,0,0,1,0,'h100,  0,        'hF,0,            0};
    tv[2]  = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'hDEADBEEF,     0,0,0,1,0,0,0,      0,        0,  0,            'hDEADBEEF};
    tv[3]  = '{1,0,0,      0,1,1,'h200,  'hABCD,   'h3,1,0,0,              0,1,0,0,1,1,'h200,  'hABCD,   'h3,0,            0};
    tv[4]  = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'h12345678,     0,0,0,1,0,0,0,      0,        0,  0,            0};
    tv[5]  = '{1,1,'h300,  0,0,0,0,      0,        0,  0,0,0,              0,0,0,0,1,0,'h300,  0,        0,  0,            0};
    tv[6]  = '{1,1,'h300,  0,0,0,0,      0,        0,  0,0,0,              0,0,0,0,1,0,'h300,  0,        0,  0,            0};
    tv[7]  = '{1,1,'h300,  0,0,0,0,      0,        0,  1,0,0,              1,0,0,0,1,0,'h300,  0,        0,  0,            0};
    tv[8]  = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'h13,           0,0,1,0,0,0,0,      0,        0,  'h13,         0};
    tv[9]  = '{1,1,'h40,   0,0,0,0,      0,        0,  1,0,0,              1,0,0,0,1,0,'h40,   0,        0,  0,            0};
    tv[10] = '{1,1,'h80,   1,0,0,0,      0,        0,  1,0,0,              0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[11] = '{1,1,'h80,   0,0,0,0,      0,        0,  1,0,0,              0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[12] = '{1,1,'h80,   0,0,0,0,      0,        0,  1,1,'h40404040,     1,0,0,0,1,0,'h80,   0,        0,  0,            0};
    tv[13] = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'h80808080,     0,0,1,0,0,0,0,      0,        0,  'h80808080,   0};
    tv[14] = '{1,0,0,      0,1,0,'h400,  0,        'hF,1,0,0,              0,1,0,0,1,0,'h400,  0,        'hF,0,            0};
    tv[15] = '{0,0,0,      0,0,0,0,      0,        0,  0,0,0,              0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[16] = '{1,0,0,      0,0,0,0,      0,        0,  0,1,'hBAD,          0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[17] = '{1,0,0,      0,1,0,'h500,  0,        'hF,1,0,0,              0,1,0,0,1,0,'h500,  0,        'hF,0,            0};
    tv[18] = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'h55AA,         0,0,0,1,0,0,0,      0,        0,  0,            'h55AA};
    tv[19] = '{1,1,'h600,  0,0,0,0,      0,        0,  1,0,0,              1,0,0,0,1,0,'h600,  0,        0,  0,            0};
    tv[20] = '{1,1,'h604,  1,0,0,0,      0,        0,  1,1,'h66,           0,0,0,0,0,0,0,      0,        0,  0,            0};
    tv[21] = '{1,1,'h604,  0,0,0,0,      0,        0,  1,0,0,              1,0,0,0,1,0,'h604,  0,        0,  0,            0};
    tv[22] = '{1,0,0,      0,0,0,0,      0,        0,  1,1,'h77,           0,0,1,0,0,0,0,      0,        0,  'h77,         0};

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed vectors, one cycle each.
    for (int k = 0; k < 23; k++) begin
      resetn = tv[k].rn; i_req = tv[k].ireq; i_addr = tv[k].iaddr; i_kill = tv[k].ikill;
      d_req = tv[k].dreq; d_we = tv[k].dwe; d_addr = tv[k].daddr; d_wdata = tv[k].dwdata;
      d_be = tv[k].dbe; mem_ready = tv[k].mrdy; mem_rvalid = tv[k].mrv; mem_rdata = tv[k].mrdata;
      e_ig = tv[k].x_ig; e_dg = tv[k].x_dg; e_irv = tv[k].x_irv; e_drv = tv[k].x_drv;
      e_mreq = tv[k].x_mreq; e_mwe = tv[k].x_mwe; e_maddr = tv[k].x_maddr;
      e_mwdata = tv[k].x_mwdata; e_mbe = tv[k].x_mbe;
      e_irdata = tv[k].x_irdata; e_drdata = tv[k].x_drdata;
      #1;
      check_all($sformatf("vec%0d", k));
      $display("vec %0d: i_gnt=%0b d_gnt=%0b i_rvalid=%0b d_rvalid=%0b mem_req=%0b mem_addr=0x%08h",
               k, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_addr);
      @(posedge clk);
      @(negedge clk);
    end

    // Both requesters saturated with a 1-cycle memory: D x SM then I.
    for (int k = 0; k < 11; k++) begin
      bit want_d, prev_d;
      want_d = (k % (SM + 1)) != SM;
      prev_d = ((k - 1) % (SM + 1)) != SM;
      i_req = (k < 10); i_addr = 32'h1000; i_kill = 0;
      d_req = (k < 10); d_we = 0; d_addr = 32'h2000; d_wdata = 0; d_be = 4'hF;
      mem_ready = 1; mem_rvalid = (k > 0); mem_rdata = 32'(k);
      #1;
      if (k < 10) begin
        chk("starve.mem_req", 32'(mem_req), 32'd1);
        chk("starve.d_gnt", 32'(d_gnt), 32'(want_d));
        chk("starve.i_gnt", 32'(i_gnt), 32'(!want_d));
        chk("starve.mem_addr", mem_addr, want_d ? 32'h2000 : 32'h1000);
      end
      if (k > 0) begin
        chk("starve.d_rvalid", 32'(d_rvalid), 32'(prev_d));
        chk("starve.i_rvalid", 32'(i_rvalid), 32'(!prev_d));
      end
      $display("starve %0d: i_gnt=%0b d_gnt=%0b i_rvalid=%0b d_rvalid=%0b",
               k, i_gnt, d_gnt, i_rvalid, d_rvalid);
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized traffic from a clean reset.
    resetn = 0; i_req = 0; d_req = 0; i_kill = 0; mem_rvalid = 0; mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
    q_own = 0; q_killed = 0; q_store = 0; q_run = 0;
    p_i = 0; p_d = 0; pi_addr = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!p_i && $urandom_range(0, 3) != 0) begin
        p_i = 1; pi_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
      end
      i_req = p_i; i_addr = pi_addr; d_req = p_d;
      i_kill = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q_own != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      #1;
      model_eval();
      check_all($sformatf("rnd%0d", cyc));
      if (e_ig || e_dg || e_irv || e_drv)
        $display("rnd %0d: i_gnt=%0b d_gnt=%0b i_rvalid=%0b d_rvalid=%0b mem_addr=0x%08h",
                 cyc, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_addr);
      if (e_ig) p_i = 0;
      if (e_dg) p_d = 0;
      @(posedge clk);
      q_own = n_own; q_killed = n_killed; q_store = n_store; q_run = n_run;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
